// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: one write port, NUM_READ packed read ports, ready flag.
// The master modport is the decode/writeback side; slave is the register file.
interface regfile_mp_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 2
);
    logic                           wen;
    logic [ADDR_WIDTH-1:0]          waddr;
    logic [DATA_WIDTH-1:0]          wdata;
    logic [NUM_READ*ADDR_WIDTH-1:0] raddr;
    logic [NUM_READ*DATA_WIDTH-1:0] rdata;
    logic                           ready;

    modport master (
        output wen, waddr, wdata, raddr,
        input  rdata, ready
    );

    modport slave (
        input  wen, waddr, wdata, raddr,
        output rdata, ready
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with self-clearing sweep after reset,
// optional hardwired-zero entry 0 and optional write-to-read bypass.
//
// state | meaning
// CLEAR | sweeping rf[ptr] <= 0, reads forced to 0, writes ignored
// RUN   | normal operation, ready high
module regfile_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    regfile_mp_if.slave  io_rf
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt;
    logic                  r_ready;
    logic                  w_ready_nxt;
    logic [DATA_WIDTH-1:0] r_rf [DEPTH];
    logic                  w_we;
    logic                  w_waddr_zero;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_ready_nxt = r_ready;
        case (r_state)
            CLEAR: begin
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                    w_state_nxt = RUN;
                    w_ready_nxt = 1'b1;
                end
            end
            RUN: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = CLEAR;
                w_ptr_nxt   = '0;
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    assign w_waddr_zero = (io_rf.waddr == '0);
    assign w_we = (r_state == RUN) && io_rf.wen && !((ZERO_REG != 0) && w_waddr_zero);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= CLEAR;
            r_ptr    <= '0;
            r_ready  <= 1'b0;
            r_rf[0]  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_ready <= w_ready_nxt;
            if (r_state == CLEAR) begin
                r_rf[r_ptr] <= '0;
            end else if (w_we) begin
                r_rf[io_rf.waddr] <= io_rf.wdata;
            end
        end
    end

    // Each read port resolves zero-register, then bypass, then array contents.
    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_ra;
        logic [DATA_WIDTH-1:0] w_rd;

        assign w_ra = io_rf.raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            w_rd = '0;
            if (r_state == RUN) begin
                if ((ZERO_REG != 0) && (w_ra == '0)) begin
                    w_rd = '0;
                end else if ((BYPASS != 0) && io_rf.wen && (io_rf.waddr == w_ra)) begin
                    w_rd = io_rf.wdata;
                end else begin
                    w_rd = r_rf[w_ra];
                end
            end
        end

        assign io_rf.rdata[gi*DATA_WIDTH +: DATA_WIDTH] = w_rd;
    end

    assign io_rf.ready = r_ready;
endmodule
